pipeline_ctrl: RTL

//  Hazard and sequencing controller for the IF/ID/EX pipeline around the decoder.

---
 rtl/pipeline_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard detection, branch flush and trap sequencing for the
// IF/ID/EX pipeline. Produces stall/bubble/flush enables, the fetch pc_sel
// mux select, a registered trap request and a saturating stall counter.
// Optional feature macro: PIPECTRL_FORWARD_EN. When it is defined, EX->ID
// forwarding is assumed and only load-use hazards stall. When it is undefined,
// any pending write in EX or MEM to a used source register stalls.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_syscall_op,
  input  logic             id_break_op,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             trap_ack,
  output logic             if_stall,
  output logic             id_stall,
  output logic             id_bubble,
  output logic             id_flush,
  output logic [1:0]       pc_sel,
  output logic             trap_req,
  output logic [1:0]       trap_cause,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The drain counter only has to hold DRAIN_CYCLES-1.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_TRAP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_SYSCALL = 2'b01;
  localparam logic [1:0] CAUSE_BREAK   = 2'b10;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    TRAP_WAIT = 2'd2,
    REDIRECT  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [DW-1:0]     cnt_reg, cnt_next;
  logic [1:0]        cause_reg, cause_next;
  logic              trap_req_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  // Source operand i: register index and whether the instruction reads it.
  logic [1:0][4:0]   src_rs;
  logic [1:0]        src_use;
  logic [1:0]        match_ex;
  logic [1:0]        match_mem;
  logic              haz_lu;
  logic              hazard;

  assign src_rs[0]  = id_rs1;
  assign src_rs[1]  = id_rs2;
  assign src_use[0] = id_use_rs1;
  assign src_use[1] = id_use_rs2;

  // Compare each used source register against the EX and MEM destinations.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign match_ex[gi]  = src_use[gi] && (src_rs[gi] == ex_rd);
      assign match_mem[gi] = src_use[gi] && (src_rs[gi] == mem_rd);
    end
  endgenerate

  // Load-use: the loaded value is not available until after MEM, even with forwarding.
  assign haz_lu = id_valid && ex_mem_read && ex_reg_write && (ex_rd != 5'd0) && (|match_ex);

`ifdef PIPECTRL_FORWARD_EN
  assign hazard = haz_lu;
`else
  // Without forwarding, wait until the producer has left MEM (writes back
  // before the consumer reads the register file).
  assign hazard = haz_lu ||
                  (id_valid && ex_reg_write  && (ex_rd  != 5'd0) && (|match_ex)) ||
                  (id_valid && mem_reg_write && (mem_rd != 5'd0) && (|match_mem));
`endif

  // Next-state and pipeline control enables; branch handling takes priority.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cause_next = cause_reg;
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    id_bubble  = 1'b0;
    id_flush   = 1'b0;
    pc_sel     = PC_SEQ;
    case (state_reg)
      RUN: begin
        if (ex_branch_taken) begin
          pc_sel    = PC_BRANCH;
          id_flush  = 1'b1;
          id_bubble = 1'b1;
        end else if (mem_busy) begin
          // Whole pipe frozen: nothing moves, so no bubble either.
          if_stall = 1'b1;
          id_stall = 1'b1;
        end else if (id_valid && (id_syscall_op || id_break_op)) begin
          cause_next = id_syscall_op ? CAUSE_SYSCALL : CAUSE_BREAK;
          cnt_next   = DRAIN_INIT;
          state_next = DRAIN;
          if_stall   = 1'b1;
          id_stall   = 1'b1;
          id_bubble  = 1'b1;
        end else if (hazard) begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          id_bubble = 1'b1;
        end
      end
      DRAIN: begin
        if (ex_branch_taken) begin
          // An older branch redirects fetch; the trapping instruction is squashed.
          pc_sel     = PC_BRANCH;
          id_flush   = 1'b1;
          id_bubble  = 1'b1;
          cause_next = CAUSE_NONE;
          state_next = RUN;
        end else begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          id_bubble = 1'b1;
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - DW'(1);
          end else if (!mem_busy) begin
            state_next = TRAP_WAIT;
          end
        end
      end
      TRAP_WAIT: begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        id_bubble = 1'b1;
        if (trap_ack) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        pc_sel     = PC_TRAP;
        id_flush   = 1'b1;
        id_bubble  = 1'b1;
        cause_next = CAUSE_NONE;
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State, trap bookkeeping and the registered trap request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      cnt_reg      <= '0;
      cause_reg    <= CAUSE_NONE;
      trap_req_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      cause_reg    <= cause_next;
      trap_req_reg <= (state_next == TRAP_WAIT);
    end
  end

  // Saturating count of cycles in which ID was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (id_stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign trap_req   = trap_req_reg;
  assign trap_cause = cause_reg;
  assign busy       = (state_reg != RUN);
  assign stall_cnt  = stall_cnt_reg;

endmodule
